// File: rtl/foo_operand_packer.sv
// foo_operand_packer
//   Upstream feeder for the two-stage pipelined adder `foo`. It pairs consecutive
//   32-bit operand beats into one 64-bit word: the first beat goes to s[63:32] and
//   the second beat goes to s[31:0]. A pair only issues while the downstream
//   result FIFO has credit. The block also regenerates a result-valid tag, because
//   `foo` has no valid signal or stall of its own.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   in_data        operand beat
//   in_valid       in_data is valid
//   in_ready       beat accepted when in_valid && in_ready
//   credit_return  one-cycle pulse: downstream popped one result
//   s              registered packed operand word to foo.s
//   s_valid        one-cycle pulse: s holds a new pair
//   res_valid      foo.out is valid (s_valid delayed LATENCY cycles)
//   credits        registered credit count
//   pairs_issued   issued pair counter, wraps at 16 bits
//   credit_err     sticky: credit returned while already at CREDITS
module foo_operand_packer #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          credit_return,
  output logic [63:0]   s,
  output logic          s_valid,
  output logic          res_valid,
  output logic [CW-1:0] credits,
  output logic [15:0]   pairs_issued,
  output logic          credit_err
);

  localparam logic [CW-1:0] CreditsMax = CW'(CREDITS);

  typedef enum logic [0:0] {StEmpty, StHaveA} state_e;

  state_e               state_q, state_d;
  logic [31:0]          hold_q, hold_d;
  logic [63:0]          s_q, s_d;
  logic                 s_valid_q;
  logic [LATENCY-1:0]   tag_q, tag_d;
  logic [CW-1:0]        credits_q, credits_d;
  logic [15:0]          pairs_q, pairs_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 hold_load;
  logic                 issue;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StHaveA;
      StHaveA: if (accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Output / control decode. The ready check uses only the registered credit
  // count, so credit_return has no combinational path to in_ready.
  always_comb begin
    in_ready  = 1'b0;
    hold_load = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      StEmpty: begin
        in_ready  = 1'b1;
        hold_load = in_valid;
      end
      StHaveA: begin
        in_ready = (credits_q != '0);
        issue    = in_valid && in_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Datapath and counters
  always_comb begin
    hold_d    = hold_load ? in_data : hold_q;
    s_d       = issue ? {hold_q, in_data} : s_q;
    pairs_d   = pairs_q + 16'(issue);
    credits_d = credits_q;
    err_d     = err_q;
    if (issue && !credit_return) begin
      credits_d = credits_q - CW'(1);
    end else if (credit_return && !issue) begin
      // Over-return saturates and is flagged rather than wrapping the count.
      if (credits_q == CreditsMax) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end
    // Tags always advance; foo cannot stall.
    tag_d    = tag_q << 1;
    tag_d[0] = s_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      tag_q     <= '0;
      credits_q <= CreditsMax;
      pairs_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      s_q       <= s_d;
      s_valid_q <= issue;
      tag_q     <= tag_d;
      credits_q <= credits_d;
      pairs_q   <= pairs_d;
      err_q     <= err_d;
    end
  end

  assign s            = s_q;
  assign s_valid      = s_valid_q;
  assign res_valid    = tag_q[LATENCY-1];
  assign credits      = credits_q;
  assign pairs_issued = pairs_q;
  assign credit_err   = err_q;

endmodule

// File: tb/tb_foo_operand_packer.sv
module tb_foo_operand_packer;

  localparam int unsigned CREDITS = 4;
  localparam int unsigned LATENCY = 3;
  localparam int unsigned CW      = $clog2(CREDITS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          credit_return = 1'b0;
  logic [63:0]   s;
  logic          s_valid;
  logic          res_valid;
  logic [CW-1:0] credits;
  logic [15:0]   pairs_issued;
  logic          credit_err;

  int checks = 0;
  int errors = 0;

  foo_operand_packer #(
    .CREDITS(CREDITS),
    .LATENCY(LATENCY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .credit_return(credit_return),
    .s            (s),
    .s_valid      (s_valid),
    .res_valid    (res_valid),
    .credits      (credits),
    .pairs_issued (pairs_issued),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          cr;
    bit          rdy;
    bit          sv;
    logic [63:0] s;
    int          cred;
    int          pairs;
    bit          res;
    bit          err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    credit_return = 1'b0;
    in_data = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one beat; returns at the negedge after it is accepted.
  task automatic send(input logic [31:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 64; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: beat %h never accepted, required accept within 64 cycles", d);
    end
  endtask

  vec_t vec [9];
  localparam logic [63:0] S35 = 64'h00000003_00000005;

  // Random-phase reference model
  bit          m_have;
  logic [31:0] m_hold;
  logic [63:0] m_s;
  bit          m_sv;
  int          m_cred;
  logic [15:0] m_pairs;
  bit          m_err;
  int          due[$];

  initial begin
    // Basic pair, res_valid latency and over-return
    vec[0] = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 64'd0, 4, 0, 1'b0, 1'b0};
    vec[1] = '{1'b1, 32'd5, 1'b0, 1'b1, 1'b0, 64'd0, 4, 0, 1'b0, 1'b0};
    vec[2] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, S35,   3, 1, 1'b0, 1'b0};
    vec[3] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, S35,   3, 1, 1'b0, 1'b0};
    vec[4] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, S35,   3, 1, 1'b0, 1'b0};
    vec[5] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, S35,   3, 1, 1'b1, 1'b0};
    vec[6] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, S35,   4, 1, 1'b0, 1'b0};
    vec[7] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, S35,   4, 1, 1'b0, 1'b1};
    vec[8] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, S35,   4, 1, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vec[i].rdy));
      chk($sformatf("vec%0d_s_valid", i), 64'(s_valid), 64'(vec[i].sv));
      chk($sformatf("vec%0d_s", i), s, vec[i].s);
      chk($sformatf("vec%0d_credits", i), 64'(credits), 64'(vec[i].cred));
      chk($sformatf("vec%0d_pairs", i), 64'(pairs_issued), 64'(vec[i].pairs));
      chk($sformatf("vec%0d_res_valid", i), 64'(res_valid), 64'(vec[i].res));
      chk($sformatf("vec%0d_credit_err", i), 64'(credit_err), 64'(vec[i].err));
      in_valid      = vec[i].v;
      in_data       = vec[i].d;
      credit_return = vec[i].cr;
      @(negedge clk);
    end
    in_valid = 1'b0;
    credit_return = 1'b0;
    repeat (4) @(negedge clk);
    chk("err_sticky", 64'(credit_err), 64'd1);
    do_reset();
    chk("err_cleared_by_rst", 64'(credit_err), 64'd0);

    // Credit exhaustion
    for (int d = 1; d <= 9; d++) send(32'(d));
    in_valid = 1'b1;
    in_data  = 32'd10;
    chk("exh_credits", 64'(credits), 64'd0);
    chk("exh_pairs", 64'(pairs_issued), 64'd4);
    chk("exh_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("exh_ready_still_low", 64'(in_ready), 64'd0);
    credit_return = 1'b1;
    chk("exh_no_comb_credit_path", 64'(in_ready), 64'd0);
    @(negedge clk);
    credit_return = 1'b0;
    chk("exh_credit_back", 64'(credits), 64'd1);
    chk("exh_ready_high", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("exh_5th_sv", 64'(s_valid), 64'd1);
    chk("exh_5th_s", s, 64'h00000009_0000000A);
    chk("exh_5th_pairs", 64'(pairs_issued), 64'd5);
    chk("exh_5th_credits", 64'(credits), 64'd0);

    // Simultaneous issue and return
    do_reset();
    for (int d = 1; d <= 4; d++) send(32'(d));
    chk("sim_start_credits", 64'(credits), 64'd2);
    send(32'd5);
    in_valid = 1'b1;
    in_data = 32'd6;
    credit_return = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    credit_return = 1'b0;
    chk("sim_sv", 64'(s_valid), 64'd1);
    chk("sim_credits_same", 64'(credits), 64'd2);
    send(32'd7);
    send(32'd8);
    chk("sim_issue_only", 64'(credits), 64'd1);
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    chk("sim_return_only", 64'(credits), 64'd2);

    // Reset mid-operation: in-flight tag and held operand dropped
    do_reset();
    send(32'hA);
    send(32'hB);
    chk("rmid_sv", 64'(s_valid), 64'd1);
    send(32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmid_s_cleared", s, 64'd0);
    chk("rmid_credits", 64'(credits), 64'(CREDITS));
    chk("rmid_pairs", 64'(pairs_issued), 64'd0);
    for (int i = 0; i < LATENCY + 2; i++) begin
      chk($sformatf("rmid_no_res%0d", i), 64'(res_valid), 64'd0);
      @(negedge clk);
    end
    send(32'h1);
    chk("rmid_first_no_issue", 64'(s_valid), 64'd0);
    send(32'h2);
    chk("rmid_sv2", 64'(s_valid), 64'd1);
    chk("rmid_s", s, 64'h00000001_00000002);
    for (int i = 1; i <= LATENCY; i++) begin
      @(negedge clk);
      chk($sformatf("rmid_res_c%0d", i), 64'(res_valid), 64'(i == LATENCY));
    end

    // Throughput: back-to-back beats, credit returned on every issue
    do_reset();
    begin
      logic [31:0] nd = 32'h100;
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("tput_sv%0d", i), 64'(s_valid), 64'(i > 0 && i % 2 == 0));
        chk($sformatf("tput_ready%0d", i), 64'(in_ready), 64'd1);
        credit_return = s_valid;
        in_valid = 1'b1;
        in_data = nd;
        nd++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      credit_return = 1'b0;
    end

    // Counter wrap
    do_reset();
    force dut.pairs_q = 16'hFFFF;
    #1;
    release dut.pairs_q;
    @(negedge clk);
    chk("wrap_preload", 64'(pairs_issued), 64'hFFFF);
    send(32'h11);
    send(32'h22);
    chk("wrap_zero", 64'(pairs_issued), 64'h0);
    chk("wrap_s", s, 64'h00000011_00000022);

    // Randomized run against the reference model
    do_reset();
    m_have = 1'b0; m_hold = '0; m_s = '0; m_sv = 1'b0;
    m_cred = CREDITS; m_pairs = '0; m_err = 1'b0;
    due.delete();
    for (int c = 0; c < 1500; c++) begin
      bit exp_res;
      bit exp_rdy;
      bit v;
      bit cr;
      bit acc;
      bit iss;
      logic [31:0] d;
      exp_res = (due.size() > 0 && due[0] == c);
      if (exp_res) void'(due.pop_front());
      exp_rdy = !m_have || (m_cred != 0);
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("rnd_s_valid", 64'(s_valid), 64'(m_sv));
      chk("rnd_s", s, m_s);
      chk("rnd_res_valid", 64'(res_valid), 64'(exp_res));
      chk("rnd_credits", 64'(credits), 64'(m_cred));
      chk("rnd_pairs", 64'(pairs_issued), 64'(m_pairs));
      chk("rnd_credit_err", 64'(credit_err), 64'(m_err));
      v  = ($urandom_range(0, 9) < 7);
      cr = ($urandom_range(0, 9) < 3);
      d  = $urandom;
      in_valid = v;
      in_data = d;
      credit_return = cr;
      acc = v && exp_rdy;
      iss = acc && m_have;
      m_sv = iss;
      if (iss) begin
        m_s = {m_hold, d};
        m_pairs = m_pairs + 16'd1;
        due.push_back(c + 1 + LATENCY);
        m_have = 1'b0;
      end else if (acc) begin
        m_hold = d;
        m_have = 1'b1;
      end
      if (iss && !cr) m_cred--;
      else if (cr && !iss) begin
        if (m_cred == CREDITS) m_err = 1'b1;
        else m_cred++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    credit_return = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
